// File: rtl/aec_expr_tx.sv
// Transmit side of the expression-calculator character interface: buffers one ASCII
// expression, streams it to the calculator and captures the result. Optional pre-scan: AEC_TX_ERRCHK_EN.
module aec_expr_tx #(
  parameter int BUF_DEPTH = 64,
  parameter int TIMEOUT   = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  logic [7:0]  wr_data,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic [31:0] result_out,
  output logic        timeout_err,
  output logic        overflow,
`ifdef AEC_TX_ERRCHK_EN
  output logic        chk_err,
`endif
  output logic        aec_ready,
  output logic [7:0]  aec_ascii,
  input  logic        aec_finish,
  input  logic [31:0] aec_result
);

  localparam int PW = $clog2(BUF_DEPTH) + 1;
  localparam int AW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [PW-1:0] FULL      = PW'(BUF_DEPTH);
  localparam logic [CW-1:0] WAIT_LAST = CW'(TIMEOUT - 1);
  localparam logic [7:0]    EQ        = 8'h3D;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_SEND,
    S_WAIT,
    S_DONE
  } state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   wait_q, wait_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic [31:0]     result_q, result_d;
  logic            timeout_q, timeout_d;
  logic            overflow_q, overflow_d;
  logic            ready_q, ready_d;
  logic [7:0]      ascii_q, ascii_d;
  logic            eq_q, eq_d;
  logic            buf_we;
  logic [7:0]      char_buf_q [BUF_DEPTH];

  logic [PW-1:0]   rd_next;
  logic [7:0]      first_char;
  logic [7:0]      next_char;

`ifdef AEC_TX_ERRCHK_EN
  logic [PW-1:0]   depth_q, depth_d, depth_n;
  logic            chk_err_q, chk_err_d;
  logic            chk_bad, chk_end, is_plain;
  logic [7:0]      cur_char;
`endif

  assign rd_next    = rd_ptr_q + 1'b1;
  assign first_char = char_buf_q[0];
  assign next_char  = char_buf_q[rd_next[AW-1:0]];

  // Output registers are loaded with the values for the state being entered, so
  // aec_ascii/aec_ready line up with the SEND cycle that owns rd_ptr_q.
  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    wait_d     = wait_q;
    result_d   = result_q;
    timeout_d  = timeout_q;
    overflow_d = overflow_q;
    eq_d       = eq_q;
    busy_d     = 1'b0;
    done_d     = 1'b0;
    ready_d    = 1'b0;
    ascii_d    = 8'h00;
    buf_we     = 1'b0;
`ifdef AEC_TX_ERRCHK_EN
    depth_d    = depth_q;
    chk_err_d  = chk_err_q;
    depth_n    = depth_q;
    chk_bad    = 1'b0;
    chk_end    = 1'b0;
    is_plain   = 1'b0;
    cur_char   = char_buf_q[rd_ptr_q[AW-1:0]];
`endif

    case (state_q)
      S_IDLE: begin
        if (wr_en) begin
          if (wr_ptr_q < FULL) begin
            buf_we   = 1'b1;
            wr_ptr_d = wr_ptr_q + 1'b1;
          end else begin
            overflow_d = 1'b1;
          end
        end else if (start && (wr_ptr_q != '0)) begin
          timeout_d  = 1'b0;
          overflow_d = 1'b0;
          rd_ptr_d   = '0;
          busy_d     = 1'b1;
`ifdef AEC_TX_ERRCHK_EN
          chk_err_d  = 1'b0;
          depth_d    = '0;
          state_d    = S_CHECK;
`else
          ready_d    = 1'b1;
          ascii_d    = first_char;
          eq_d       = (first_char == EQ);
          state_d    = S_SEND;
`endif
        end
      end

`ifdef AEC_TX_ERRCHK_EN
      S_CHECK: begin
        busy_d   = 1'b1;
        is_plain = ((cur_char >= 8'h30) && (cur_char <= 8'h39)) ||
                   ((cur_char >= 8'h61) && (cur_char <= 8'h66)) ||
                   (cur_char == 8'h2A) || (cur_char == 8'h2B) || (cur_char == 8'h2D);
        if (cur_char == 8'h28) begin
          depth_n = depth_q + 1'b1;
        end else if (cur_char == 8'h29) begin
          if (depth_q == '0) chk_bad = 1'b1;
          else               depth_n = depth_q - 1'b1;
        end else if (cur_char == EQ) begin
          chk_end = 1'b1;
        end else if (!is_plain) begin
          chk_bad = 1'b1;
        end
        if (rd_next == wr_ptr_q) chk_end = 1'b1;

        if (chk_bad || (chk_end && (depth_n != '0))) begin
          chk_err_d = 1'b1;
          result_d  = 32'd0;
          busy_d    = 1'b0;
          done_d    = 1'b1;
          state_d   = S_DONE;
        end else if (chk_end) begin
          rd_ptr_d  = '0;
          ready_d   = 1'b1;
          ascii_d   = first_char;
          eq_d      = (first_char == EQ);
          state_d   = S_SEND;
        end else begin
          rd_ptr_d  = rd_next;
          depth_d   = depth_n;
        end
      end
`endif

      S_SEND: begin
        busy_d = 1'b1;
        // Finish may arrive combinationally while '=' is on the bus.
        if (eq_q) begin
          if (aec_finish) begin
            result_d = aec_result;
            busy_d   = 1'b0;
            done_d   = 1'b1;
            state_d  = S_DONE;
          end else begin
            wait_d   = '0;
            state_d  = S_WAIT;
          end
        end else begin
          rd_ptr_d = rd_next;
          if (rd_next < wr_ptr_q) begin
            ascii_d = next_char;
            eq_d    = (next_char == EQ);
          end else begin
            ascii_d = EQ;
            eq_d    = 1'b1;
          end
        end
      end

      S_WAIT: begin
        busy_d = 1'b1;
        if (aec_finish) begin
          result_d = aec_result;
          busy_d   = 1'b0;
          done_d   = 1'b1;
          state_d  = S_DONE;
        end else if (wait_q == WAIT_LAST) begin
          timeout_d = 1'b1;
          result_d  = 32'd0;
          busy_d    = 1'b0;
          done_d    = 1'b1;
          state_d   = S_DONE;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end

      S_DONE: begin
        wr_ptr_d = '0;
        state_d  = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      wait_q     <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      result_q   <= 32'd0;
      timeout_q  <= 1'b0;
      overflow_q <= 1'b0;
      ready_q    <= 1'b0;
      ascii_q    <= 8'h00;
      eq_q       <= 1'b0;
`ifdef AEC_TX_ERRCHK_EN
      depth_q    <= '0;
      chk_err_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      wait_q     <= wait_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      result_q   <= result_d;
      timeout_q  <= timeout_d;
      overflow_q <= overflow_d;
      ready_q    <= ready_d;
      ascii_q    <= ascii_d;
      eq_q       <= eq_d;
`ifdef AEC_TX_ERRCHK_EN
      depth_q    <= depth_d;
      chk_err_q  <= chk_err_d;
`endif
    end
  end

  // Buffer contents survive reset and transactions; only wr_ptr defines validity.
  always_ff @(posedge clk) begin
    if (buf_we) char_buf_q[wr_ptr_q[AW-1:0]] <= wr_data;
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign result_out  = result_q;
  assign timeout_err = timeout_q;
  assign overflow    = overflow_q;
  assign aec_ready   = ready_q;
  assign aec_ascii   = ascii_q;
`ifdef AEC_TX_ERRCHK_EN
  assign chk_err     = chk_err_q;
`endif

endmodule

// File: tb/tb_aec_expr_tx.sv
// Directed self-checking bench for aec_expr_tx (default build, TIMEOUT=16).
`timescale 1ns/1ps
module tb_aec_expr_tx;

  localparam int BUF_DEPTH = 64;
  localparam int TIMEOUT   = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en;
  logic [7:0]  wr_data;
  logic        start;
  logic        busy;
  logic        done;
  logic [31:0] result_out;
  logic        timeout_err;
  logic        overflow;
  logic        aec_ready;
  logic [7:0]  aec_ascii;
  logic        aec_finish;
  logic [31:0] aec_result;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  aec_expr_tx #(
    .BUF_DEPTH(BUF_DEPTH),
    .TIMEOUT  (TIMEOUT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .wr_en      (wr_en),
    .wr_data    (wr_data),
    .start      (start),
    .busy       (busy),
    .done       (done),
    .result_out (result_out),
    .timeout_err(timeout_err),
    .overflow   (overflow),
    .aec_ready  (aec_ready),
    .aec_ascii  (aec_ascii),
    .aec_finish (aec_finish),
    .aec_result (aec_result)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Writes a string into the buffer; optionally raises start with the last byte.
  task automatic applyStimulus(input string s, input bit start_on_last);
    for (int i = 0; i < s.len(); i++) begin
      wr_en   = 1'b1;
      wr_data = s[i];
      start   = start_on_last && (i == s.len() - 1);
      tick();
    end
    wr_en = 1'b0;
    start = 1'b0;
  endtask

  // finish_at: 0 = finish with '=', k>0 = finish in WAIT cycle k-1, <0 = never.
  task automatic runTransaction(input string tag, input string exp_chars, input int finish_at,
                                input logic [31:0] calc_result, input int exp_wait,
                                input bit exp_timeout, input bit noisy, input bit poke);
    int cyc;
    int n;
    n = exp_chars.len();
    start = 1'b1;
    tick();
    start = 1'b0;
    checkOutput({tag, " timeout_clr"}, 32'(timeout_err), 32'd0);
    checkOutput({tag, " overflow_clr"}, 32'(overflow), 32'd0);
    checkOutput({tag, " busy_send"}, 32'(busy), 32'd1);
    for (int i = 0; i < n; i++) begin
      checkOutput($sformatf("%s char%0d", tag, i), 32'(aec_ascii), 32'(exp_chars[i]));
      checkOutput($sformatf("%s ready%0d", tag, i), 32'(aec_ready), 32'(i == 0));
      aec_finish = noisy && (i < n - 1);
      aec_result = 32'hDEAD_BEEF;
      if ((i == n - 1) && (finish_at == 0)) begin
        aec_finish = 1'b1;
        aec_result = calc_result;
      end
      if (poke && (i == 1)) begin
        wr_en   = 1'b1;
        wr_data = "7";
        start   = 1'b1;
      end
      tick();
      aec_finish = 1'b0;
      wr_en      = 1'b0;
      start      = 1'b0;
    end
    cyc = 0;
    while ((done !== 1'b1) && (cyc < 64)) begin
      if (cyc == 0) begin
        checkOutput({tag, " wait_ascii"}, 32'(aec_ascii), 32'd0);
        checkOutput({tag, " wait_ready"}, 32'(aec_ready), 32'd0);
        checkOutput({tag, " wait_busy"}, 32'(busy), 32'd1);
        if (poke) begin
          start = 1'b1;
          wr_en = 1'b1;
        end
      end
      if (cyc == finish_at - 1) begin
        aec_finish = 1'b1;
        aec_result = calc_result;
      end
      tick();
      aec_finish = 1'b0;
      start      = 1'b0;
      wr_en      = 1'b0;
      cyc++;
    end
    checkOutput({tag, " wait_cycles"}, 32'(cyc), 32'(exp_wait));
    checkOutput({tag, " done"}, 32'(done), 32'd1);
    checkOutput({tag, " result"}, result_out, exp_timeout ? 32'd0 : calc_result);
    checkOutput({tag, " timeout_err"}, 32'(timeout_err), 32'(exp_timeout));
    checkOutput({tag, " busy_done"}, 32'(busy), 32'd0);
    checkOutput({tag, " overflow_end"}, 32'(overflow), 32'd0);
    tick();
    checkOutput({tag, " done_pulse"}, 32'(done), 32'd0);
  endtask

  initial begin
    rst        = 1'b1;
    wr_en      = 1'b0;
    wr_data    = 8'h00;
    start      = 1'b0;
    aec_finish = 1'b0;
    aec_result = 32'd0;
    tick();
    tick();
    rst = 1'b0;
    checkOutput("rst busy", 32'(busy), 32'd0);
    checkOutput("rst done", 32'(done), 32'd0);
    checkOutput("rst result", result_out, 32'd0);
    checkOutput("rst timeout", 32'(timeout_err), 32'd0);
    checkOutput("rst overflow", 32'(overflow), 32'd0);
    checkOutput("rst ready", 32'(aec_ready), 32'd0);
    checkOutput("rst ascii", 32'(aec_ascii), 32'd0);

    start = 1'b1;
    tick();
    start = 1'b0;
    checkOutput("empty_start busy", 32'(busy), 32'd0);
    checkOutput("empty_start ready", 32'(aec_ready), 32'd0);

    applyStimulus("(1+2)*3=", 1'b0);
    runTransaction("paren", "(1+2)*3=", 3, 32'd9, 3, 1'b0, 1'b1, 1'b0);

    applyStimulus("a*b", 1'b0);
    runTransaction("noeq", "a*b=", 2, 32'd110, 2, 1'b0, 1'b0, 1'b0);

    applyStimulus("1+1=", 1'b0);
    runTransaction("tmo", "1+1=", -1, 32'd0, TIMEOUT, 1'b1, 1'b0, 1'b0);

    applyStimulus("5", 1'b0);
    applyStimulus("=", 1'b1);
    checkOutput("wr_start_same busy", 32'(busy), 32'd0);
    runTransaction("five", "5=", 0, 32'd5, 0, 1'b0, 1'b0, 1'b0);

    applyStimulus("9=", 1'b0);
    for (int i = 0; i < BUF_DEPTH - 2; i++) applyStimulus("0", 1'b0);
    checkOutput("ovf at_full", 32'(overflow), 32'd0);
    applyStimulus("1", 1'b0);
    checkOutput("ovf dropped", 32'(overflow), 32'd1);
    runTransaction("ovf", "9=", 3, 32'd9, 3, 1'b0, 1'b0, 1'b1);

    applyStimulus("(1+2)*3=", 1'b0);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    checkOutput("mid_rst pre_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("mid_rst busy", 32'(busy), 32'd0);
    checkOutput("mid_rst done", 32'(done), 32'd0);
    checkOutput("mid_rst result", result_out, 32'd0);
    checkOutput("mid_rst ready", 32'(aec_ready), 32'd0);
    checkOutput("mid_rst ascii", 32'(aec_ascii), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput($sformatf("mid_rst no_done%0d", i), 32'(done), 32'd0);
    end
    applyStimulus("7-2=", 1'b0);
    runTransaction("after_rst", "7-2=", 1, 32'd5, 1, 1'b0, 1'b0, 1'b0);

    start = 1'b1;
    tick();
    start = 1'b0;
    checkOutput("post_done empty busy", 32'(busy), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
